// File: rtl/pwm_ramp_gen_if.sv
// Control/status bundle between the speed logic, the PWM generator and the
// H-bridge stage. The master side drives the run request, the target duty and
// the overcurrent flags. The slave side, the PWM generator, returns the pulse
// and its status.
interface pwm_ramp_gen_if;
  logic        enable;
  logic [19:0] duty;
  logic [1:0]  oc;
  logic        pulse;
  logic [19:0] active_duty;
  logic        period_start;
  logic        fault;

  modport master (
    output enable, duty, oc,
    input  pulse, active_duty, period_start, fault
  );

  modport slave (
    input  enable, duty, oc,
    output pulse, active_duty, period_start, fault
  );
endinterface

// File: rtl/pwm_ramp_gen.sv
// Fixed-period PWM generator for the motor H-bridge.
// - Soft start/stop: the applied duty moves toward the target by at most STEP
//   counts per period.
// - Overcurrent lockout: a filtered OC flag locks out the output, and the block
//   retries after RETRY_PERIODS full periods.
// - Registered outputs: every output comes from a register. Each register is
//   loaded from next-state values, so pulse lines up with the counter.
module pwm_ramp_gen #(
  parameter int unsigned PERIOD        = 983040,
  parameter int unsigned STEP          = 65535,
  parameter int unsigned OC_FILT       = 8,
  parameter int unsigned RETRY_PERIODS = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  pwm_ramp_gen_if.slave  bus
);

  localparam int unsigned OC_W = $clog2(OC_FILT + 1);
  localparam int unsigned RT_W = $clog2(RETRY_PERIODS + 1);

  localparam logic [19:0]     CNT_LAST = 20'(PERIOD - 1);
  localparam logic [20:0]     PERIOD_W = 21'(PERIOD);
  // A step larger than the period behaves exactly like a step of one period.
  localparam logic [20:0]     STEP_W   = (STEP > PERIOD) ? 21'(PERIOD) : 21'(STEP);
  localparam logic [OC_W-1:0] OC_MAX   = OC_W'(OC_FILT);
  localparam logic [RT_W-1:0] RT_LAST  = RT_W'(RETRY_PERIODS - 1);

  typedef enum logic {RUN, FAULT} state_t;

  state_t            state_q, state_d;
  logic [19:0]       cnt_q, cnt_d;
  logic [19:0]       duty_q, duty_d;
  logic [OC_W-1:0]   oc_cnt_q, oc_cnt_d;
  logic [RT_W-1:0]   retry_q, retry_d;
  logic              pulse_q, pulse_d;
  logic              ps_q, ps_d;
  logic              fault_q, fault_d;

  logic              wrap;
  logic              oc_any;
  logic [20:0]       tgt, cur, up, dn;

  assign wrap   = (cnt_q == CNT_LAST);
  assign oc_any = |bus.oc;

  // The target is clamped to a full period. The 21-bit differences cannot
  // wrap because each one is used only when its sign is known.
  assign tgt = ({1'b0, bus.duty} > PERIOD_W) ? PERIOD_W : {1'b0, bus.duty};
  assign cur = {1'b0, duty_q};
  assign up  = tgt - cur;
  assign dn  = cur - tgt;

  // Next-state logic: counter, OC filter, RUN/FAULT machine, ramp and outputs.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path through
    // this block can leave a value unassigned and infer a latch.
    state_d  = state_q;
    cnt_d    = wrap ? '0 : cnt_q + 1'b1;
    duty_d   = duty_q;
    retry_d  = retry_q;
    oc_cnt_d = !oc_any ? '0 : ((oc_cnt_q == OC_MAX) ? OC_MAX : oc_cnt_q + 1'b1);

    case (state_q)
      RUN: begin
        if (oc_cnt_d == OC_MAX) begin
          // Fault detection wins over both the disable path and the ramp.
          state_d = FAULT;
          duty_d  = '0;
          retry_d = '0;
        end else if (!bus.enable) begin
          duty_d = '0;
        end else if (wrap) begin
          if (tgt > cur) begin
            duty_d = 20'(cur + ((up > STEP_W) ? STEP_W : up));
          end else if (cur > tgt) begin
            duty_d = 20'(cur - ((dn > STEP_W) ? STEP_W : dn));
          end
        end
      end
      FAULT: begin
        duty_d = '0;
        if (wrap) begin
          if (retry_q == RT_LAST) begin
            // Retry only on a quiet bridge; otherwise wait another full count.
            retry_d = '0;
            if (!oc_any) state_d = RUN;
          end else begin
            retry_d = retry_q + 1'b1;
          end
        end
      end
      default: state_d = RUN;
    endcase

    pulse_d = (state_d == RUN) && bus.enable && (cnt_d < duty_d);
    ps_d    = (cnt_d == '0);
    fault_d = (state_d == FAULT);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      duty_q   <= '0;
      oc_cnt_q <= '0;
      retry_q  <= '0;
      pulse_q  <= 1'b0;
      ps_q     <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here make every register sample the
      // values from before this edge, whatever the statement order.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      duty_q   <= duty_d;
      oc_cnt_q <= oc_cnt_d;
      retry_q  <= retry_d;
      pulse_q  <= pulse_d;
      ps_q     <= ps_d;
      fault_q  <= fault_d;
    end
  end

  assign bus.pulse        = pulse_q;
  assign bus.active_duty  = duty_q;
  assign bus.period_start = ps_q;
  assign bus.fault        = fault_q;

endmodule

// File: tb/tb_pwm_ramp_gen.sv
// Self-checking bench for pwm_ramp_gen (PERIOD=16, STEP=4, OC_FILT=3,
// RETRY_PERIODS=2).
// - Each rising edge advances a behavioural model and queues the outputs
//   expected for the following cycle.
// - The next falling edge pops the queued entry and compares it with the DUT.
// - Directed checks against fixed values mark the milestones of each scenario.
module tb_pwm_ramp_gen;

  localparam int P = 16;
  localparam int S = 4;
  localparam int F = 3;
  localparam int R = 2;

  typedef struct {
    logic        pulse;
    logic [19:0] ad;
    logic        ps;
    logic        fault;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pwm_ramp_gen_if bus ();

  pwm_ramp_gen #(
    .PERIOD(P), .STEP(S), .OC_FILT(F), .RETRY_PERIODS(R)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  // Model state.
  int m_cnt, m_ad, m_oc, m_retry;
  bit m_fault;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_ad = 0; m_oc = 0; m_retry = 0; m_fault = 1'b0;
  endtask

  // One clock edge of the model, written from the behavioural description.
  task automatic model_edge();
    bit   wrap, oc_any;
    int   new_oc, tgt;
    exp_t e;
    wrap   = (m_cnt == P - 1);
    oc_any = (bus.oc != 2'b00);
    new_oc = oc_any ? ((m_oc < F) ? m_oc + 1 : F) : 0;
    if (!m_fault) begin
      if (new_oc == F) begin
        m_fault = 1'b1; m_ad = 0; m_retry = 0;
      end else if (!bus.enable) begin
        m_ad = 0;
      end else if (wrap) begin
        tgt = (int'(bus.duty) > P) ? P : int'(bus.duty);
        if (tgt > m_ad)      m_ad = m_ad + ((tgt - m_ad > S) ? S : tgt - m_ad);
        else if (tgt < m_ad) m_ad = m_ad - ((m_ad - tgt > S) ? S : m_ad - tgt);
      end
    end else begin
      m_ad = 0;
      if (wrap) begin
        if (m_retry + 1 == R) begin
          m_retry = 0;
          if (!oc_any) m_fault = 1'b0;
        end else begin
          m_retry++;
        end
      end
    end
    m_cnt = wrap ? 0 : m_cnt + 1;
    m_oc  = new_oc;
    e.ad    = 20'(m_ad);
    e.ps    = (m_cnt == 0);
    e.fault = m_fault;
    e.pulse = !m_fault && bus.enable && (m_cnt < m_ad);
    sb.push_back(e);
  endtask

  // One clock: the model pushes on the rising edge, the falling edge pops and compares.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("pulse",        {31'd0, bus.pulse},        {31'd0, e.pulse});
      check("active_duty",  {12'd0, bus.active_duty},  {12'd0, e.ad});
      check("period_start", {31'd0, bus.period_start}, {31'd0, e.ps});
      check("fault",        {31'd0, bus.fault},        {31'd0, e.fault});
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Runs until the first cycle after the next wrap edge (at most one period).
  task automatic run_to_wrap();
    for (int i = 0; i < P; i++) begin
      tick();
      if (m_cnt == 0) break;
    end
  endtask

  // Counts pulse-high cycles over one full period, starting in a cnt==0 cycle.
  task automatic count_period(output int n);
    n = int'(bus.pulse);
    for (int i = 1; i < P; i++) begin
      tick();
      n += int'(bus.pulse);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pulse"}, {31'd0, bus.pulse},        32'd0);
    check({tag, "_ad"},    {12'd0, bus.active_duty},  32'd0);
    check({tag, "_ps"},    {31'd0, bus.period_start}, 32'd0);
    check({tag, "_fault"}, {31'd0, bus.fault},        32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.enable = 1'b1;
    bus.duty   = 20'd10;
    bus.oc     = 2'b00;

    // Reset, with outputs checked while reset is still held.
    #3 rst_n = 1'b0;
    #1 check_all_zero("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Ramp 0 -> 4 -> 8 -> 10.
    run_to_wrap(); check("ramp_w1", {12'd0, bus.active_duty}, 32'd4);
    run_to_wrap(); check("ramp_w2", {12'd0, bus.active_duty}, 32'd8);
    run_to_wrap(); check("ramp_w3", {12'd0, bus.active_duty}, 32'd10);
    count_period(n); check("pulses_10", n, 32'd10);

    // A duty change mid-period waits for the wrap: 10 -> 6 -> 2.
    ticks(5);
    bus.duty = 20'd2;
    ticks(3);
    check("hold_mid", {12'd0, bus.active_duty}, 32'd10);
    run_to_wrap(); check("down_w1", {12'd0, bus.active_duty}, 32'd6);
    run_to_wrap(); check("down_w2", {12'd0, bus.active_duty}, 32'd2);

    // Full-scale duty saturates at PERIOD; duty=0 then ramps back to 0.
    bus.duty = 20'hFFFFF;
    for (int i = 0; i < 4; i++) run_to_wrap();
    check("sat_16", {12'd0, bus.active_duty}, 32'd16);
    count_period(n); check("pulses_16", n, 32'd16);
    bus.duty = 20'd0;
    for (int i = 0; i < 4; i++) run_to_wrap();
    check("zero_ad", {12'd0, bus.active_duty}, 32'd0);
    count_period(n); check("pulses_0", n, 32'd0);

    // A short OC glitch is filtered out; three cycles trip a fault.
    bus.duty = 20'd10;
    run_to_wrap(); run_to_wrap();
    bus.oc = 2'b01; ticks(2);
    bus.oc = 2'b00; ticks(1);
    check("oc_glitch", {31'd0, bus.fault}, 32'd0);
    bus.oc = 2'b10; ticks(3);
    check("oc_fault", {31'd0, bus.fault}, 32'd1);
    check("oc_pulse", {31'd0, bus.pulse}, 32'd0);
    bus.oc = 2'b00;
    run_to_wrap(); check("retry_w1", {31'd0, bus.fault}, 32'd1);
    run_to_wrap(); check("retry_w2", {31'd0, bus.fault}, 32'd0);
    check("retry_ad0", {12'd0, bus.active_duty}, 32'd0);
    run_to_wrap(); check("retry_ramp", {12'd0, bus.active_duty}, 32'd4);

    // OC held through the retry point keeps the block in FAULT.
    bus.oc = 2'b11; ticks(3);
    check("hold_fault", {31'd0, bus.fault}, 32'd1);
    run_to_wrap(); run_to_wrap();
    check("hold_retry", {31'd0, bus.fault}, 32'd1);
    bus.oc = 2'b00;
    run_to_wrap(); check("rel_w1", {31'd0, bus.fault}, 32'd1);
    run_to_wrap(); check("rel_w2", {31'd0, bus.fault}, 32'd0);
    run_to_wrap(); check("rel_ramp", {12'd0, bus.active_duty}, 32'd4);

    // Dropping enable mid-ramp clears the duty at once; re-enable ramps from 0.
    bus.duty = 20'd16;
    run_to_wrap(); check("en_ramp", {12'd0, bus.active_duty}, 32'd8);
    ticks(3);
    bus.enable = 1'b0; ticks(1);
    check("en_off_ad", {12'd0, bus.active_duty}, 32'd0);
    check("en_off_pulse", {31'd0, bus.pulse}, 32'd0);
    ticks(5);
    bus.enable = 1'b1;
    run_to_wrap(); check("en_back", {12'd0, bus.active_duty}, 32'd4);

    // Asynchronous reset in the middle of a fault.
    bus.oc = 2'b10; ticks(3);
    check("pre_rst_fault", {31'd0, bus.fault}, 32'd1);
    ticks(2);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    bus.oc = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run_to_wrap(); check("post_rst_ramp", {12'd0, bus.active_duty}, 32'd4);
    run_to_wrap();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
